dlx_mem_arbiter: RTL and testbench
==================================

Name: dlx_mem_arbiter

Overview:
Shares one single-port, variable-latency memory between the DLX instruction-fetch port (IAddr/IRead/IIn) and the data port (DAddr/DRead/DWrite/DOut/DIn). It arbitrates between the two requesters and sequences the memory request/acknowledge handshake. It returns read data with per-port ready pulses, which the core uses as stall releases. It also polices misaligned accesses and hung memory with a timeout.

Parameters:
ADDR_W, 32, byte-address width on both CPU ports and on the memory side.
DATA_W, 32, data word width.
TIMEOUT, 15, maximum cycles MReq may wait for MAck before the access is aborted (range 1..255).
D_MAX_RUN, 3, maximum consecutive D grants while an I request is pending before I is forced.

Ports:
PHI1  in  1  clock, all state on rising edge.
MRST  in  1  asynchronous active-low reset.
IAddr  in  ADDR_W  instruction byte address.
IRead  in  1  instruction read request, level, held until IReady.
IIn  out  DATA_W  instruction word to core.
IReady  out  1  one-cycle pulse: IIn valid / fetch complete.
DAddr  in  ADDR_W  data byte address.
DRead  in  1  data read request, level, held until DReady.
DWrite  in  1  data write request, level, held until DReady.
DOut  in  DATA_W  write data from core.
DIn  out  DATA_W  read data to core.
DReady  out  1  one-cycle pulse: data access complete.
BusErr  out  1  one-cycle pulse coincident with the failing port's Ready (misalign, timeout, DRead&DWrite).
MAddr  out  ADDR_W  memory byte address.
MWData  out  DATA_W  memory write data.
MReq  out  1  memory request, held until MAck or timeout.
MWe  out  1  1 = write, valid while MReq.
MAck  in  1  memory acknowledge, one cycle; MRData valid in the same cycle.
MRData  in  DATA_W  memory read data.

Behaviour:
- Reset (MRST=0, asynchronous):
  - State IDLE.
  - IIn, DIn, MAddr, MWData = 0.
  - IReady, DReady, BusErr, MReq, MWe = 0.
  - D run counter and timeout counter = 0.
  - Reset mid-access drops MReq immediately; the access is lost, with no Ready pulse.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE arbitration, sampled at the rising edge:
  - D request = DRead|DWrite.
  - D has priority over I.
  - Exception: if I is pending and the D run counter equals D_MAX_RUN, I wins.
  - The counter increments on each D grant made while I is pending, and clears on any I grant or when I is not pending.
  - No request: remain in IDLE.
- Grant, checked at the grant edge:
  - If the address is misaligned (bits[1:0] != 0), or DRead&DWrite are both set: no memory access. Go directly to DONE, with Ready, BusErr=1 and data=0.
  - Otherwise, register MAddr/MWData/MWe and set MReq=1; go to BUSY_I or BUSY_D.
  - MReq rises one cycle after the request is sampled.
- BUSY_x:
  - MReq, MAddr, MWData and MWe are held stable.
  - The timeout counter increments each cycle MAck=0.
  - On MAck=1: capture MRData into IIn (BUSY_I) or DIn (BUSY_D read); writes leave DIn unchanged. Drop MReq and go to DONE.
  - If the counter reaches TIMEOUT with no MAck: drop MReq, set the port data to 0 and go to DONE with BusErr.
  - MAck arriving in IDLE or DONE is ignored.
- DONE:
  - For exactly one cycle, the granted port's Ready=1 (and BusErr if flagged).
  - Then IDLE; the timeout counter clears.
  - Request lines are not sampled in DONE, so a request still high during the Ready cycle is treated as a new request at the next IDLE edge.
- Latency:
  - Best case, MAck in the first BUSY cycle: request sampled at edge N, MReq high N..N+1, Ready high N+1..N+2.
  - Minimum spacing between back-to-back grants is 3 cycles.
- Data outputs IIn/DIn hold their last value until the next completion on that port.
- Requester protocol: address and data must stay stable while the request is high; a request dropped before its Ready is a protocol violation, and the access still completes.

Test Plan:
- Reset and single fetch: release MRST, IRead=1, IAddr=0x8, memory acks after 2 cycles with 0x20210001 -> MReq high 2 cycles, MAddr=0x8, MWe=0, IReady pulses once, IIn=0x20210001, BusErr=0.
- Simultaneous requests: IRead and DRead both asserted at the same edge, DAddr=0x40 -> D granted first (DReady, DIn=MRData), then I granted in the following IDLE, IReady pulses after.
- Fairness: DWrite held continuously with a new address each DReady, IRead held -> exactly D_MAX_RUN=3 DReady pulses, then an IReady, then D resumes.
- Misaligned and illegal accesses:
  - DAddr=0x42 with DRead -> no MReq, DReady and BusErr in the same cycle, DIn=0.
  - DRead&DWrite both set -> same response.
- Timeout: IRead, MAck held 0 -> MReq drops after exactly 15 cycles, then IReady with BusErr=1 and IIn=0; a late MAck is ignored.
- Reset mid-access: assert MRST=0 while in BUSY_D -> MReq=0 immediately, no DReady; after release, a new DWrite completes normally with MWData=DOut.

Source files
------------

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates the DLX instruction-fetch and data ports onto one variable-latency
// memory, with misalign/illegal-access policing and an MAck timeout.
module dlx_mem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned D_MAX_RUN = 3
) (
    input  logic              PHI1,
    input  logic              MRST,
    input  logic [ADDR_W-1:0] IAddr,
    input  logic              IRead,
    output logic [DATA_W-1:0] IIn,
    output logic              IReady,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic              DRead,
    input  logic              DWrite,
    input  logic [DATA_W-1:0] DOut,
    output logic [DATA_W-1:0] DIn,
    output logic              DReady,
    output logic              BusErr,
    output logic [ADDR_W-1:0] MAddr,
    output logic [DATA_W-1:0] MWData,
    output logic              MReq,
    output logic              MWe,
    input  logic              MAck,
    input  logic [DATA_W-1:0] MRData
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t            state_q;
    logic [7:0]        tmo_q;
    logic [7:0]        run_q;
    logic [DATA_W-1:0] iin_q, din_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;
    logic              iready_q, dready_q, buserr_q, mreq_q, mwe_q;

    logic d_req, i_win, d_win, d_bad, i_bad;

    // I overrides D priority only once D has run D_MAX_RUN grants past a waiting fetch.
    always_comb begin
        d_req = DRead | DWrite;
        i_win = IRead & (~d_req | (run_q == 8'(D_MAX_RUN)));
        d_win = d_req & ~i_win;
        d_bad = (DAddr[1:0] != 2'b00) | (DRead & DWrite);
        i_bad = (IAddr[1:0] != 2'b00);
    end

    always_ff @(posedge PHI1 or negedge MRST) begin
        if (!MRST) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            run_q    <= '0;
            iin_q    <= '0;
            din_q    <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            iready_q <= 1'b0;
            dready_q <= 1'b0;
            buserr_q <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!IRead) run_q <= '0;
                    if (i_win) begin
                        run_q <= '0;
                        if (i_bad) begin
                            iin_q    <= '0;
                            iready_q <= 1'b1;
                            buserr_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            maddr_q <= IAddr;
                            mwe_q   <= 1'b0;
                            mreq_q  <= 1'b1;
                            state_q <= BUSY_I;
                        end
                    end else if (d_win) begin
                        if (IRead) run_q <= run_q + 8'd1;
                        if (d_bad) begin
                            din_q    <= '0;
                            dready_q <= 1'b1;
                            buserr_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            maddr_q  <= DAddr;
                            mwdata_q <= DOut;
                            mwe_q    <= DWrite;
                            mreq_q   <= 1'b1;
                            state_q  <= BUSY_D;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (MAck) begin
                        mreq_q <= 1'b0;
                        mwe_q  <= 1'b0;
                        if (state_q == BUSY_I) begin
                            iin_q    <= MRData;
                            iready_q <= 1'b1;
                        end else begin
                            if (!mwe_q) din_q <= MRData;
                            dready_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                        // This cycle is the TIMEOUT-th without MAck: abort.
                        if (tmo_q == 8'(TIMEOUT - 1)) begin
                            mreq_q   <= 1'b0;
                            mwe_q    <= 1'b0;
                            buserr_q <= 1'b1;
                            if (state_q == BUSY_I) begin
                                iin_q    <= '0;
                                iready_q <= 1'b1;
                            end else begin
                                din_q    <= '0;
                                dready_q <= 1'b1;
                            end
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    iready_q <= 1'b0;
                    dready_q <= 1'b0;
                    buserr_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IIn    = iin_q;
    assign DIn    = din_q;
    assign IReady = iready_q;
    assign DReady = dready_q;
    assign BusErr = buserr_q;
    assign MAddr  = maddr_q;
    assign MWData = mwdata_q;
    assign MReq   = mreq_q;
    assign MWe    = mwe_q;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed bench for dlx_mem_arbiter: fetch, priority, fairness, bus errors,
// timeout and mid-access reset, with hand-computed expectations.
module tb_dlx_mem_arbiter;

    logic        PHI1, MRST;
    logic [31:0] IAddr, IIn, DAddr, DOut, DIn, MAddr, MWData, MRData;
    logic        IRead, IReady, DRead, DWrite, DReady, BusErr, MReq, MWe, MAck;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    dlx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .D_MAX_RUN(3)) dut (
        .PHI1(PHI1), .MRST(MRST),
        .IAddr(IAddr), .IRead(IRead), .IIn(IIn), .IReady(IReady),
        .DAddr(DAddr), .DRead(DRead), .DWrite(DWrite), .DOut(DOut), .DIn(DIn),
        .DReady(DReady), .BusErr(BusErr),
        .MAddr(MAddr), .MWData(MWData), .MReq(MReq), .MWe(MWe),
        .MAck(MAck), .MRData(MRData)
    );

    initial PHI1 = 1'b0;
    always #5 PHI1 = ~PHI1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PHI1);
        #1;
    endtask

    // Called just after the grant edge; MAck rises in BUSY cycle number ack_after.
    task automatic do_mem(input int unsigned ack_after, input logic [31:0] rdata);
        for (int unsigned i = 1; i < ack_after; i++) begin
            MAck = 1'b0;
            tick();
        end
        MAck   = 1'b1;
        MRData = rdata;
        tick();
        MAck   = 1'b0;
    endtask

    logic [31:0] daddr, dout, iaddr;
    bit          exp_d [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int unsigned cnt;

    initial begin
        MRST = 1'b0; IRead = 1'b0; DRead = 1'b0; DWrite = 1'b0; MAck = 1'b0;
        IAddr = '0; DAddr = '0; DOut = '0; MRData = '0;
        tick(); tick();

        check("rst_ctrl", {MReq, MWe, IReady, DReady, BusErr}, 5'b0);
        check("rst_iin", IIn, 32'h0);
        check("rst_din", DIn, 32'h0);
        check("rst_maddr", MAddr, 32'h0);
        check("rst_mwdata", MWData, 32'h0);

        // Single fetch, MAck in second BUSY cycle
        MRST = 1'b1;
        tick();
        IRead = 1'b1; IAddr = 32'h8;
        tick();
        check("f_mreq1", MReq, 1'b1);
        check("f_maddr", MAddr, 32'h8);
        check("f_mwe", MWe, 1'b0);
        tick();
        check("f_mreq2", MReq, 1'b1);
        check("f_noready", IReady, 1'b0);
        MAck = 1'b1; MRData = 32'h20210001;
        tick();
        MAck = 1'b0; IRead = 1'b0;
        check("f_mreq_drop", MReq, 1'b0);
        check("f_iready", IReady, 1'b1);
        check("f_iin", IIn, 32'h20210001);
        check("f_buserr", BusErr, 1'b0);
        tick();
        check("f_iready_pulse", IReady, 1'b0);

        // Simultaneous I and D: D first
        IRead = 1'b1; IAddr = 32'h10; DRead = 1'b1; DAddr = 32'h40;
        tick();
        check("s_maddr_d", MAddr, 32'h40);
        check("s_mreq", MReq, 1'b1);
        do_mem(1, 32'hDEADBEEF);
        check("s_dready", {DReady, IReady}, 2'b10);
        check("s_din", DIn, 32'hDEADBEEF);
        DRead = 1'b0;
        tick();
        tick();
        check("s_maddr_i", MAddr, 32'h10);
        do_mem(1, 32'h11112222);
        check("s_iready", {IReady, DReady}, 2'b10);
        check("s_iin", IIn, 32'h11112222);
        check("s_din_hold", DIn, 32'hDEADBEEF);
        IRead = 1'b0;
        tick();

        // Fairness: D,D,D,I,D with both held
        daddr = 32'h100; dout = 32'hA0; iaddr = 32'h20;
        DWrite = 1'b1; DAddr = daddr; DOut = dout;
        IRead = 1'b1; IAddr = iaddr;
        for (int g = 0; g < 5; g++) begin
            tick();
            if (exp_d[g]) begin
                check("fair_daddr", MAddr, daddr);
                check("fair_wdata", {MWe, MWData}, {1'b1, dout});
                do_mem(1, 32'h0);
                check("fair_dready", {DReady, IReady}, 2'b10);
                daddr = daddr + 32'd4; dout = dout + 32'd1;
                DAddr = daddr; DOut = dout;
            end else begin
                check("fair_iaddr", MAddr, iaddr);
                check("fair_iwe", MWe, 1'b0);
                do_mem(1, 32'h900D0000 + 32'(g));
                check("fair_iready", {IReady, DReady}, 2'b10);
                check("fair_iin", IIn, 32'h900D0003);
                iaddr = iaddr + 32'd4;
                IAddr = iaddr;
            end
            tick();
        end
        check("fair_din_hold", DIn, 32'hDEADBEEF);
        DWrite = 1'b0; IRead = 1'b0;
        tick();

        // Misaligned D read
        DRead = 1'b1; DAddr = 32'h42;
        tick();
        check("mis_mreq", MReq, 1'b0);
        check("mis_rdy_err", {DReady, BusErr}, 2'b11);
        check("mis_din", DIn, 32'h0);
        DRead = 1'b0;
        tick();
        check("mis_pulse", {DReady, BusErr}, 2'b00);

        // Valid read to make DIn nonzero, then DRead&DWrite
        DRead = 1'b1; DAddr = 32'h48;
        tick();
        do_mem(1, 32'h55AA55AA);
        check("rd_din", DIn, 32'h55AA55AA);
        DRead = 1'b0;
        tick();
        DRead = 1'b1; DWrite = 1'b1; DAddr = 32'h44;
        tick();
        check("rw_mreq", MReq, 1'b0);
        check("rw_rdy_err", {DReady, BusErr}, 2'b11);
        check("rw_din", DIn, 32'h0);
        DRead = 1'b0; DWrite = 1'b0;
        tick();

        // Timeout on a fetch
        IRead = 1'b1; IAddr = 32'h30; MAck = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!MReq) break;
            cnt++;
            tick();
        end
        check("to_mreq_cycles", cnt, 15);
        check("to_rdy_err", {IReady, BusErr}, 2'b11);
        check("to_iin", IIn, 32'h0);
        IRead = 1'b0;
        MAck = 1'b1; MRData = 32'hBAD0BAD0;
        tick();
        tick();
        MAck = 1'b0;
        check("to_late_iin", IIn, 32'h0);
        check("to_late_ctrl", {MReq, IReady, BusErr}, 3'b000);

        // Reset mid-access, then a clean write
        DWrite = 1'b1; DAddr = 32'h80; DOut = 32'hCAFEF00D;
        tick();
        check("mr_mwdata", MWData, 32'hCAFEF00D);
        tick();
        #2 MRST = 1'b0;
        #1;
        check("mr_mreq_drop", MReq, 1'b0);
        check("mr_nodready", DReady, 1'b0);
        tick();
        check("mr_nodready2", DReady, 1'b0);
        DAddr = 32'h84; DOut = 32'h12345678;
        MRST = 1'b1;
        tick();
        check("mr_new_req", {MReq, MWe}, 2'b11);
        check("mr_new_addr", MAddr, 32'h84);
        check("mr_new_wdata", MWData, 32'h12345678);
        do_mem(2, 32'h0);
        check("mr_new_done", {DReady, BusErr}, 2'b10);
        DWrite = 1'b0;
        tick();
        check("mr_pulse", DReady, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
